spi_sram_arbiter: RTL

//  Shares one spi_sram_encoder between two requesters: port A (Hack CPU data/instr

---
 rtl/spi_sram_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/spi_sram_arbiter.sv
// Two-port arbiter in front of a single spi_sram_encoder. Round-robin between
// port A (CPU) and port B (loader/debug), one encoder transaction at a time.
module spi_sram_arbiter #(
  parameter int unsigned WORD_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,

  input  logic                     a_req,
  input  logic                     a_we,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [WORD_WIDTH-1:0]    a_wdata,
  output logic                     a_ack,

  input  logic                     b_req,
  input  logic                     b_we,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [WORD_WIDTH-1:0]    b_wdata,
  output logic                     b_ack,

  output logic [WORD_WIDTH-1:0]    rdata,
  output logic                     ready,

  output logic                     mem_request,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     mem_write_enable,
  output logic [WORD_WIDTH-1:0]    mem_data_out,
  input  logic [WORD_WIDTH-1:0]    mem_data_in,
  input  logic                     mem_busy,
  input  logic                     mem_initialized
);

  localparam logic [2:0] WAIT_INIT = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] ISSUE     = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] RESPOND   = 3'd4;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  logic [2:0]               state_q, state_d;
  logic                     last_grant_q, last_grant_d;
  logic                     a_ack_q, a_ack_d;
  logic                     b_ack_q, b_ack_d;
  logic                     ready_q, ready_d;
  logic                     mem_request_q, mem_request_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     we_q, we_d;
  logic [WORD_WIDTH-1:0]    wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     grant_b;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    a_ack_d       = 1'b0;
    b_ack_d       = 1'b0;
    mem_request_d = mem_request_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    grant_b       = 1'b0;

    case (state_q)
      WAIT_INIT: begin
        if (mem_initialized) state_d = IDLE;
      end
      IDLE: begin
        if (a_req || b_req) begin
          // B wins if it is alone, or if both ask and A was served last.
          grant_b       = b_req && (!a_req || (last_grant_q == GRANT_A));
          last_grant_d  = grant_b ? GRANT_B : GRANT_A;
          addr_d        = grant_b ? b_addr  : a_addr;
          we_d          = grant_b ? b_we    : a_we;
          wdata_d       = grant_b ? b_wdata : a_wdata;
          mem_request_d = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_busy) begin
          mem_request_d = 1'b0;
          state_d       = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!mem_busy) begin
          if (!we_q) rdata_d = mem_data_in;
          if (last_grant_q == GRANT_B) b_ack_d = 1'b1;
          else                         a_ack_d = 1'b1;
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d       = WAIT_INIT;
        mem_request_d = 1'b0;
      end
    endcase

    // Encoder lost init: drop whatever was in flight; the client keeps its
    // request and is served again once init completes.
    if (!mem_initialized && (state_q != WAIT_INIT)) begin
      state_d       = WAIT_INIT;
      mem_request_d = 1'b0;
      a_ack_d       = 1'b0;
      b_ack_d       = 1'b0;
      last_grant_d  = last_grant_q;
      addr_d        = addr_q;
      we_d          = we_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
    end

    ready_d = (state_d != WAIT_INIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= WAIT_INIT;
      last_grant_q  <= GRANT_B;
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      ready_q       <= 1'b0;
      mem_request_q <= 1'b0;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      a_ack_q       <= a_ack_d;
      b_ack_q       <= b_ack_d;
      ready_q       <= ready_d;
      mem_request_q <= mem_request_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
    end
  end

  assign a_ack            = a_ack_q;
  assign b_ack            = b_ack_q;
  assign ready            = ready_q;
  assign rdata            = rdata_q;
  assign mem_request      = mem_request_q;
  assign mem_address      = addr_q;
  assign mem_write_enable = we_q;
  assign mem_data_out     = wdata_q;

endmodule
